// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad encoder: FSM states,
// matrix dimensions, key map and small row/column helpers.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } estado_t;

  localparam int N_FILAS    = 4;
  localparam int N_COLUMNAS = 4;

  // Indexed by {row, column}.
  localparam logic [3:0] MAPA [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] drive_fila(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-index column pulled low; only meaningful when some bit is low.
  function automatic logic [1:0] primera_columna(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = N_COLUMNAS - 1; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all
// ones so an idle keypad reads as "no key".
module sincronizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_codificador.sv
// 4x4 keypad scanner: walks the rows, debounces one press and release, and
// emits one Codigo_U per accepted press. State is exposed on `estado`.
module teclado_codificador
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] Codigo_U,
  output logic       code_valid,
  output logic       key_down,
  output estado_t    estado
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  // The cycle that detects or first sees the change counts as one stable
  // cycle, so the counter finishes one step early on the terminal compare.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 2);

  logic [3:0]    col_s;
  logic [1:0]    fila;
  logic [1:0]    col;
  logic [SW-1:0] cnt_scan;
  logic [DW-1:0] cnt_deb;

  sincronizador #(.W(N_COLUMNAS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (columnas),
    .q     (col_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= SCAN;
      fila       <= 2'd0;
      col        <= 2'd0;
      cnt_scan   <= '0;
      cnt_deb    <= '0;
      filas      <= 4'b1110;
      Codigo_U   <= 4'h0;
      code_valid <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      case (estado)
        SCAN: begin
          if (cnt_scan == SCAN_LAST) begin
            cnt_scan <= '0;
            if (col_s != 4'hF) begin
              col     <= primera_columna(col_s);
              cnt_deb <= '0;
              estado  <= DEBOUNCE;
            end else begin
              fila  <= fila + 2'd1;
              filas <= drive_fila(fila + 2'd1);
            end
          end else begin
            cnt_scan <= cnt_scan + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s[col]) begin
            cnt_scan <= '0;
            estado   <= SCAN;
          end else if (cnt_deb == DEB_LAST) begin
            Codigo_U   <= MAPA[{fila, col}];
            code_valid <= 1'b1;
            key_down   <= 1'b1;
            estado     <= PRESSED;
          end else begin
            cnt_deb <= cnt_deb + 1'b1;
          end
        end
        PRESSED: begin
          if (col_s[col]) begin
            cnt_deb <= '0;
            estado  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!col_s[col]) begin
            estado <= PRESSED;
          end else if (cnt_deb == DEB_LAST) begin
            key_down <= 1'b0;
            fila     <= 2'd0;
            filas    <= 4'b1110;
            cnt_scan <= '0;
            estado   <= SCAN;
          end else begin
            cnt_deb <= cnt_deb + 1'b1;
          end
        end
        default: estado <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_teclado_codificador.sv
// Bench for teclado_codificador with a pin-level keypad model and an
// expected-code queue derived from the printed key legends.
module tb_teclado_codificador;
  import teclado_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] Codigo_U;
  logic       code_valid;
  logic       key_down;
  estado_t    estado;

  logic       teclas [4][4];
  logic [3:0] exp_q [$];
  int         n_checks;
  int         n_pass;
  int         n_pulses;

  teclado_codificador #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .columnas   (columnas),
    .filas      (filas),
    .Codigo_U   (Codigo_U),
    .code_valid (code_valid),
    .key_down   (key_down),
    .estado     (estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a closed key shorts its column to its row while that row is low.
  always_comb begin
    columnas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (teclas[r][c] && !filas[r]) columnas[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] legend_code(input int r, input int c);
    string km;
    byte   ch;
    km = "123A456B789CE0FD";
    ch = km[r * 4 + c];
    if (ch >= "A") return 4'(ch - "A" + 10);
    return 4'(ch - "0");
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    teclas[r][c] = v;
  endtask

  task automatic wait_key_down(input string tag, input int budget);
    int k;
    k = 0;
    while (!key_down && k < budget) begin
      step(1);
      k++;
    end
    check(tag, key_down, 1'b1);
  endtask

  // scoreboard: every code_valid must match the oldest expected code
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_row_low", $countones(~filas), 1);
      if (code_valid) begin
        n_pulses++;
        check("kd_with_pulse", key_down, 1'b1);
        check("pulse_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("code_value", Codigo_U, exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    int k;
    int r;
    int c;
    n_checks = 0;
    n_pass   = 0;
    n_pulses = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) teclas[i][j] = 1'b0;
    rst_n = 1'b0;
    step(3);
    check("rst_filas", filas, 4'b1110);
    check("rst_code", Codigo_U, 4'h0);
    check("rst_valid", code_valid, 1'b0);
    check("rst_kd", key_down, 1'b0);
    rst_n = 1'b1;

    // idle scan walk: row changes every SCAN_DIV cycles
    for (int i = 0; i < 64; i++) begin
      check("walk_filas", filas, ~(32'd1 << ((i / SCAN_DIV) % 4)) & 32'hF);
      step(1);
    end
    check("idle_pulses", n_pulses, 0);
    check("idle_code", Codigo_U, 4'h0);

    // key 6 at row1/col2
    p0 = n_pulses;
    exp_q.push_back(legend_code(1, 2));
    set_key(1, 2, 1'b1);
    step(100);
    check("k6_pulses", n_pulses - p0, 1);
    check("k6_code", Codigo_U, 4'h6);
    check("k6_kd", key_down, 1'b1);
    check("k6_row_frozen", filas, 4'b1101);
    set_key(1, 2, 1'b0);
    step(30);
    check("k6_released", key_down, 1'b0);

    // bounce on key 0 (row3/col1)
    p0 = n_pulses;
    for (int i = 0; i < 10; i++) begin
      set_key(3, 1, (i % 2) == 0);
      step(3);
    end
    check("bounce_no_pulse", n_pulses - p0, 0);
    exp_q.push_back(legend_code(3, 1));
    set_key(3, 1, 1'b1);
    step(100);
    check("bounce_pulses", n_pulses - p0, 1);
    check("bounce_code", Codigo_U, 4'h0);
    set_key(3, 1, 1'b0);
    step(30);

    // release glitch on key D (row3/col3)
    p0 = n_pulses;
    exp_q.push_back(legend_code(3, 3));
    set_key(3, 3, 1'b1);
    wait_key_down("kd_press_D", 80);
    step(5);
    set_key(3, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("glitch_kd", key_down, 1'b1);
    end
    set_key(3, 3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_hold_kd", key_down, 1'b1);
    end
    set_key(3, 3, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("kd_fall_timing", key_down, i < 10);
    end
    step(30);
    check("D_pulses", n_pulses - p0, 1);
    check("D_code", Codigo_U, 4'hD);

    // rollover: 5 held, 9 added, 5 released while 9 held
    p0 = n_pulses;
    exp_q.push_back(legend_code(1, 1));
    set_key(1, 1, 1'b1);
    wait_key_down("kd_press_5", 80);
    set_key(2, 2, 1'b1);
    step(40);
    check("roll_one_code", n_pulses - p0, 1);
    check("roll_code5", Codigo_U, 4'h5);
    exp_q.push_back(legend_code(2, 2));
    set_key(1, 1, 1'b0);
    step(80);
    check("roll_two_codes", n_pulses - p0, 2);
    check("roll_code9", Codigo_U, 4'h9);
    check("roll_kd9", key_down, 1'b1);
    set_key(2, 2, 1'b0);
    step(30);

    // reset in the middle of debouncing key A (row0/col3)
    p0 = n_pulses;
    set_key(0, 3, 1'b1);
    k = 0;
    while (estado != DEBOUNCE && k < 60) begin
      step(1);
      k++;
    end
    check("reached_debounce", estado == DEBOUNCE, 1'b1);
    step(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_filas", filas, 4'b1110);
    check("mid_rst_code", Codigo_U, 4'h0);
    check("mid_rst_valid", code_valid, 1'b0);
    check("mid_rst_kd", key_down, 1'b0);
    set_key(0, 3, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(40);
    check("no_A_after_rst", n_pulses - p0, 0);
    exp_q.push_back(legend_code(0, 3));
    set_key(0, 3, 1'b1);
    step(100);
    check("A_after_rehold", n_pulses - p0, 1);
    check("A_code", Codigo_U, 4'hA);
    set_key(0, 3, 1'b0);
    step(30);

    // random single-key presses
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      p0 = n_pulses;
      exp_q.push_back(legend_code(r, c));
      set_key(r, c, 1'b1);
      step($urandom_range(50, 90));
      check("rnd_kd_held", key_down, 1'b1);
      check("rnd_code", Codigo_U, legend_code(r, c));
      set_key(r, c, 1'b0);
      step($urandom_range(25, 40));
      check("rnd_kd_rel", key_down, 1'b0);
      check("rnd_pulses", n_pulses - p0, 1);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
